// File: rtl/alu_mul_seq_pkg.sv
// Shared types for the shift-and-add multiplier controller: FSM states and
// the six-bit Hack ALU control word.
package alu_mul_seq_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADD  = 3'd1,
        ST_DBL  = 3'd2,
        ST_FLAG = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Field order matches the ALU pins: zx nx zy ny f no
    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } alu_op_t;

    localparam alu_op_t OP_ADD   = 6'b000010;
    localparam alu_op_t OP_PASSX = 6'b001100;
    localparam alu_op_t OP_ZERO  = 6'b101010;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Coprocessor handshake between the CPU (master) and the multiplier (slave).
interface alu_mul_seq_if;
    import alu_mul_seq_pkg::*;

    logic              start;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] result;
    logic              zr;
    logic              ng;
    logic              busy;
    logic              done;

    modport master (output start, a, b, input result, zr, ng, busy, done);
    modport slave  (input start, a, b, output result, zr, ng, busy, done);

endinterface

// File: rtl/alu.sv
// Shared Hack-style 16-bit ALU: optional zero/negate on each input, add or
// and, optional negate on the output, plus zero and negative flags.
module alu (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        zx,
    input  logic        nx,
    input  logic        zy,
    input  logic        ny,
    input  logic        f,
    input  logic        no,
    output logic [15:0] out,
    output logic        zr,
    output logic        ng
);

    logic [15:0] x_z, x_n, y_z, y_n, f_out;

    always_comb begin
        x_z   = zx ? 16'h0000 : x;
        x_n   = nx ? ~x_z : x_z;
        y_z   = zy ? 16'h0000 : y;
        y_n   = ny ? ~y_z : y_z;
        f_out = f ? (x_n + y_n) : (x_n & y_n);
        out   = no ? ~f_out : f_out;
        zr    = (out == 16'h0000);
        ng    = out[15];
    end

endmodule

// File: rtl/alu_mul_seq.sv
// Multi-cycle 16x16 multiplier (low half) that drives the shared ALU through
// shift-and-add iterations; the ALU is its only arithmetic resource.
module alu_mul_seq
    import alu_mul_seq_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic          clk,
    input  logic          reset,
    alu_mul_seq_if.slave  bus
);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   acc, m, n;
    logic [WIDTH-1:0]   result_r;
    logic               zr_r, ng_r;
    logic               busy_c, done_c;

    alu_op_t            op;
    logic [WIDTH-1:0]   alu_x, alu_y, alu_out;
    logic               alu_zr, alu_ng;
    logic               n_zero;

    assign n_zero = (n == '0);

    alu u_alu (
        .x   (alu_x),
        .y   (alu_y),
        .zx  (op.zx),
        .nx  (op.nx),
        .zy  (op.zy),
        .ny  (op.ny),
        .f   (op.f),
        .no  (op.no),
        .out (alu_out),
        .zr  (alu_zr),
        .ng  (alu_ng)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.start) state_nxt = ST_ADD;
            ST_ADD:  state_nxt = n_zero ? ST_FLAG : ST_DBL;
            ST_DBL:  state_nxt = ST_ADD;
            ST_FLAG: state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The ALU sits at OP_ZERO whenever no state needs it.
    always_comb begin
        op     = OP_ZERO;
        alu_x  = '0;
        alu_y  = '0;
        busy_c = 1'b0;
        done_c = 1'b0;
        case (state)
            ST_ADD: begin
                op     = OP_ADD;
                alu_x  = acc;
                alu_y  = m;
                busy_c = 1'b1;
            end
            ST_DBL: begin
                op     = OP_ADD;
                alu_x  = m;
                alu_y  = m;
                busy_c = 1'b1;
            end
            ST_FLAG: begin
                op     = OP_PASSX;
                alu_x  = acc;
                busy_c = 1'b1;
            end
            ST_DONE: done_c = 1'b1;
            default: ;
        endcase
    end

    // Reset clears everything so an aborted operation leaves no partial result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc      <= '0;
            m        <= '0;
            n        <= '0;
            result_r <= '0;
            zr_r     <= 1'b0;
            ng_r     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (bus.start) begin
                    m   <= bus.a;
                    n   <= bus.b;
                    acc <= '0;
                end
                ST_ADD: if (!n_zero && n[0]) acc <= alu_out;
                ST_DBL: begin
                    m <= alu_out;
                    n <= n >> 1;
                end
                ST_FLAG: begin
                    result_r <= alu_out;
                    zr_r     <= alu_zr;
                    ng_r     <= alu_ng;
                end
                default: ;
            endcase
        end
    end

    assign bus.result = result_r;
    assign bus.zr     = zr_r;
    assign bus.ng     = ng_r;
    assign bus.busy   = busy_c;
    assign bus.done   = done_c;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq against a plain-arithmetic model of the
// product and of the 2k+3 cycle latency.
module tb_alu_mul_seq;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    alu_mul_seq_if bus ();

    alu_mul_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [15:0] ref_prod(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        p = {16'd0, a} * {16'd0, b};
        return p[15:0];
    endfunction

    function automatic int ref_lat(input logic [15:0] b);
        int k;
        k = 0;
        for (int i = 0; i < 16; i++) if (b[i]) k = i + 1;
        return 2 * k + 3;
    endfunction

    // Issues one start at a negedge in IDLE and returns at the negedge of the
    // first IDLE cycle after done; optionally pulses a second start at inj_cyc.
    task automatic run_op(input logic [15:0] ia, input logic [15:0] ib,
                          input int inj_cyc, input logic [15:0] ja, input logic [15:0] jb,
                          output int cyc, output logic [15:0] res,
                          output logic rzr, output logic rng,
                          output bit busy_ok, output bit held_ok);
        logic [15:0] r0;
        bit          seen;
        r0      = bus.result;
        busy_ok = 1'b1;
        held_ok = 1'b1;
        seen    = 1'b0;
        cyc     = 0;
        res     = '0;
        rzr     = 1'b0;
        rng     = 1'b0;
        bus.a = ia;
        bus.b = ib;
        bus.start = 1'b1;
        while (!seen && cyc < 60) begin
            @(negedge clk);
            cyc++;
            bus.start = 1'b0;
            bus.a = 16'($urandom);
            bus.b = 16'($urandom);
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                res  = bus.result;
                rzr  = bus.zr;
                rng  = bus.ng;
                if (bus.busy !== 1'b0) busy_ok = 1'b0;
            end else begin
                if (bus.busy !== 1'b1) busy_ok = 1'b0;
                if (bus.result !== r0) held_ok = 1'b0;
            end
            if (cyc == inj_cyc) begin
                bus.start = 1'b1;
                bus.a = ja;
                bus.b = jb;
            end
        end
        if (!seen) cyc = -1;
        @(negedge clk);
        bus.start = 1'b0;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) busy_ok = 1'b0;
        if (bus.result !== res) held_ok = 1'b0;
    endtask

    task automatic test_reset;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks += 5;
        if (bus.result !== 16'h0000) begin errors++; $display("FAIL reset_result: got %h expected 0000", bus.result); end
        if (bus.zr !== 1'b0) begin errors++; $display("FAIL reset_zr: got %b expected 0", bus.zr); end
        if (bus.ng !== 1'b0) begin errors++; $display("FAIL reset_ng: got %b expected 0", bus.ng); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input int inj_cyc, input logic [15:0] ja, input logic [15:0] jb);
        int          cyc;
        logic [15:0] res, exp;
        logic        rzr, rng;
        bit          bok, hok;
        exp = ref_prod(a, b);
        run_op(a, b, inj_cyc, ja, jb, cyc, res, rzr, rng, bok, hok);
        checks += 6;
        if (cyc !== ref_lat(b)) begin errors++; $display("FAIL %s latency a=%h b=%h: got %0d expected %0d", tag, a, b, cyc, ref_lat(b)); end
        if (res !== exp) begin errors++; $display("FAIL %s result a=%h b=%h: got %h expected %h", tag, a, b, res, exp); end
        if (rzr !== (exp == 16'h0)) begin errors++; $display("FAIL %s zr a=%h b=%h: got %b expected %b", tag, a, b, rzr, exp == 16'h0); end
        if (rng !== exp[15]) begin errors++; $display("FAIL %s ng a=%h b=%h: got %b expected %b", tag, a, b, rng, exp[15]); end
        if (bok !== 1'b1) begin errors++; $display("FAIL %s busy_done_window a=%h b=%h: got %b expected 1", tag, a, b, bok); end
        if (hok !== 1'b1) begin errors++; $display("FAIL %s result_hold a=%h b=%h: got %b expected 1", tag, a, b, hok); end
    endtask

    task automatic test_directed;
        logic [15:0] ta [5] = '{16'h0003, 16'h1234, 16'hFFFD, 16'hFFFF, 16'h0100};
        logic [15:0] tb [5] = '{16'h0005, 16'h0000, 16'h0005, 16'hFFFF, 16'h0100};
        for (int i = 0; i < 5; i++) check_op("directed", ta[i], tb[i], -1, 16'h0, 16'h0);
    endtask

    task automatic test_ignored_start;
        check_op("ignore_busy", 16'h0007, 16'h0009, 4, 16'h0002, 16'h0002);
        check_op("ignore_flag", 16'h0007, 16'h0009, 10, 16'h0002, 16'h0002);
        check_op("ignore_done", 16'h0007, 16'h0009, 11, 16'h0002, 16'h0002);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++)
            check_op("back_to_back", 16'($urandom), 16'($urandom), -1, 16'h0, 16'h0);
    endtask

    task automatic test_random;
        logic [15:0] a, b;
        for (int i = 0; i < 30; i++) begin
            a = 16'($urandom);
            b = 16'($urandom) & 16'((32'h1 << $urandom_range(0, 16)) - 1);
            check_op("random", a, b, -1, 16'h0, 16'h0);
        end
    endtask

    task automatic test_reset_abort;
        int cyc;
        check_op("pre_abort", 16'h8001, 16'h0003, -1, 16'h0, 16'h0);
        bus.a = 16'h0007;
        bus.b = 16'hFFFF;
        bus.start = 1'b1;
        cyc = 0;
        while (cyc < 10) begin
            @(negedge clk);
            cyc++;
            bus.start = 1'b0;
        end
        reset = 1'b1;
        #1;
        checks += 5;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
        if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", bus.done); end
        if (bus.result !== 16'h0000) begin errors++; $display("FAIL abort_result: got %h expected 0000", bus.result); end
        if (bus.zr !== 1'b0) begin errors++; $display("FAIL abort_zr: got %b expected 0", bus.zr); end
        if (bus.ng !== 1'b0) begin errors++; $display("FAIL abort_ng: got %b expected 0", bus.ng); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_op("post_abort", 16'h0002, 16'h0003, -1, 16'h0, 16'h0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignored_start();
        test_back_to_back();
        test_random();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
